// File: rtl/synth_pkg.sv
// Shared sizing, phase/slot types and index helper for the oscillator slot pipeline.
package synth_pkg;
  localparam int VOICES  = 8;
  localparam int V_OSC   = 4;
  localparam int V_WIDTH = 3;
  localparam int O_WIDTH = 2;
  localparam int PH_W    = 32;
  localparam int LUT_AW  = 11;
  localparam int SLOTS   = VOICES * V_OSC;
  localparam int S_WIDTH = V_WIDTH + O_WIDTH;

  typedef logic [PH_W-1:0] phase_t;

  typedef struct packed {
    logic [V_WIDTH-1:0] vx;
    logic [O_WIDTH-1:0] ox;
  } slot_t;

  // Flat register-file index of a slot: {vx, ox}.
  function automatic logic [S_WIDTH-1:0] slot_idx(input slot_t s);
    return {s.vx, s.ox};
  endfunction
endpackage

// File: rtl/phase_store.sv
// Register file holding one phase word per oscillator slot.
// Combinational read port, single synchronous write port, asynchronous clear.
module phase_store
  import synth_pkg::*;
(
  input  logic               sCLK_XVXOSC,
  input  logic               reset_reg_N,
  input  logic               we,
  input  logic [S_WIDTH-1:0] waddr,
  input  phase_t             wdata,
  input  logic [S_WIDTH-1:0] raddr,
  output phase_t             rdata
);

  phase_t mem [SLOTS];

  always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      for (int i = 0; i < SLOTS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/osc_phase_accum.sv
// Time-multiplexed phase accumulator: one phase word per slot, FM offset added
// to the top phase bits to form the sine-LUT address, with per-voice hard sync.
module osc_phase_accum
  import synth_pkg::*;
#(
  parameter int MOD_SHL = 0
) (
  input  logic               sCLK_XVXOSC,
  input  logic               reset_reg_N,
  input  logic               slot_valid,
  input  logic [V_WIDTH-1:0] vx,
  input  logic [O_WIDTH-1:0] ox,
  input  phase_t             osc_inc,
  input  logic [10:0]        modulation,
  input  logic [VOICES-1:0]  note_on,
  output logic [LUT_AW-1:0]  lut_addr,
  output logic               lut_valid,
  output logic [V_WIDTH-1:0] lut_vx,
  output logic [O_WIDTH-1:0] lut_ox
);

  // Handshake: slot_valid qualifies vx/ox/osc_inc/modulation for exactly one
  // cycle with no back-pressure; lut_valid qualifies lut_* two cycles later.

  slot_t              in_slot;
  slot_t              s0_slot;
  logic               s0_valid;
  phase_t             s0_inc;
  logic [10:0]        s0_mod;
  logic               s0_rst;
  phase_t             s0_ph;
  logic [VOICES-1:0]  pend;
  logic [VOICES-1:0]  clr_mask;
  phase_t             store_rdata;
  phase_t             ph_use;
  phase_t             ph_wb;
  phase_t             ph_rd;
  logic               fwd;
  logic signed [LUT_AW-1:0] mod_ext;
  logic [LUT_AW-1:0]  addr_next;

  assign in_slot.vx = vx;
  assign in_slot.ox = ox;

  // S1 datapath: hard-sync select, accumulate, address with FM offset.
  assign ph_use    = s0_rst ? '0 : s0_ph;
  assign ph_wb     = ph_use + s0_inc;
  assign mod_ext   = LUT_AW'(signed'(s0_mod));
  assign addr_next = ph_use[PH_W-1 -: LUT_AW] + LUT_AW'(mod_ext <<< MOD_SHL);

  // A slot re-entering S0 while its previous pass is being written back
  // must see the new value, not the stale store contents.
  assign fwd   = s0_valid && (s0_slot == in_slot);
  assign ph_rd = fwd ? ph_wb : store_rdata;

  phase_store u_store (
    .sCLK_XVXOSC (sCLK_XVXOSC),
    .reset_reg_N (reset_reg_N),
    .we          (s0_valid),
    .waddr       (slot_idx(s0_slot)),
    .wdata       (ph_wb),
    .raddr       (slot_idx(in_slot)),
    .rdata       (store_rdata)
  );

  always_comb begin
    clr_mask = '0;
    if (slot_valid && (ox == O_WIDTH'(V_OSC - 1))) clr_mask[vx] = 1'b1;
  end

  // A note_on coinciding with the clearing slot wins so the next pass resyncs.
  always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~clr_mask) | note_on;
    end
  end

  always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      s0_valid <= 1'b0;
      s0_slot  <= '0;
      s0_inc   <= '0;
      s0_mod   <= '0;
      s0_rst   <= 1'b0;
      s0_ph    <= '0;
    end else begin
      s0_valid <= slot_valid;
      s0_slot  <= in_slot;
      s0_inc   <= osc_inc;
      s0_mod   <= modulation;
      s0_rst   <= pend[vx];
      s0_ph    <= ph_rd;
    end
  end

  always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      lut_valid <= 1'b0;
      lut_addr  <= '0;
      lut_vx    <= '0;
      lut_ox    <= '0;
    end else begin
      lut_valid <= s0_valid;
      if (s0_valid) begin
        lut_addr <= addr_next;
        lut_vx   <= s0_slot.vx;
        lut_ox   <= s0_slot.ox;
      end
    end
  end

endmodule

// File: tb/tb_osc_phase_accum.sv
// Self-checking bench for osc_phase_accum: a sequential phase/pend model pushes
// expected {vx, ox, addr} per driven slot; a monitor pops on each lut_valid.
module tb_osc_phase_accum;
  import synth_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               slot_valid;
  logic [V_WIDTH-1:0] vx;
  logic [O_WIDTH-1:0] ox;
  phase_t             osc_inc;
  logic [10:0]        modulation;
  logic [VOICES-1:0]  note_on;
  logic [LUT_AW-1:0]  lut_addr;
  logic               lut_valid;
  logic [V_WIDTH-1:0] lut_vx;
  logic [O_WIDTH-1:0] lut_ox;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0]       exp_q[$];
  logic [31:0]       ph_m [SLOTS];
  logic [VOICES-1:0] pend_m;
  logic [15:0]       mon_e;

  osc_phase_accum dut (
    .sCLK_XVXOSC (clk),
    .reset_reg_N (rst_n),
    .slot_valid  (slot_valid),
    .vx          (vx),
    .ox          (ox),
    .osc_inc     (osc_inc),
    .modulation  (modulation),
    .note_on     (note_on),
    .lut_addr    (lut_addr),
    .lut_valid   (lut_valid),
    .lut_vx      (lut_vx),
    .lut_ox      (lut_ox)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < SLOTS; i++) ph_m[i] = '0;
    pend_m = '0;
    exp_q.delete();
  endtask

  // Reference model of one accepted slot, evaluated in drive order.
  task automatic model_slot(input int v, input int o, input logic [31:0] inc,
                            input logic [10:0] m, input logic [7:0] non);
    int          s;
    logic [31:0] pu;
    logic [10:0] a;
    s  = v * V_OSC + o;
    pu = pend_m[v] ? 32'h0 : ph_m[s];
    ph_m[s] = pu + inc;
    a  = pu[31:21] + m;
    exp_q.push_back({3'(v), 2'(o), a});
    if (o == V_OSC - 1) pend_m[v] = 1'b0;
    pend_m = pend_m | non;
  endtask

  // Driver tasks
  task automatic drive(input int v, input int o, input logic [31:0] inc,
                       input logic [10:0] m, input logic [7:0] non);
    @(posedge clk);
    #1;
    slot_valid = 1'b1;
    vx         = 3'(v);
    ox         = 2'(o);
    osc_inc    = inc;
    modulation = m;
    note_on    = non;
    model_slot(v, o, inc, m, non);
  endtask

  task automatic idle(input int n, input logic [7:0] non);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      slot_valid = 1'b0;
      note_on    = (i == 0) ? non : 8'h00;
      pend_m     = pend_m | ((i == 0) ? non : 8'h00);
    end
  endtask

  task automatic drive_voice(input int v, input logic [31:0] inc, input logic [10:0] m);
    for (int o = 0; o < V_OSC; o++) drive(v, o, inc, m, 8'h00);
  endtask

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n && lut_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'(lut_valid), 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("lut_vx",   32'(lut_vx),   32'(mon_e[15:13]));
        check("lut_ox",   32'(lut_ox),   32'(mon_e[12:11]));
        check("lut_addr", 32'(lut_addr), 32'(mon_e[10:0]));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    slot_valid = 1'b0; vx = '0; ox = '0; osc_inc = '0; modulation = '0; note_on = '0;
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_addr",  32'(lut_addr),  32'h0);
    check("rst_valid", 32'(lut_valid), 32'h0);
    check("rst_vx",    32'(lut_vx),    32'h0);
    check("rst_ox",    32'(lut_ox),    32'h0);
    @(posedge clk); #1; rst_n = 1'b1;

    // 1: slot (0,0), inc 2^21 each pass, plus latency check on the first pass
    drive(0, 0, 32'h0020_0000, 11'h000, 8'h00);
    @(posedge clk); #1; slot_valid = 1'b0;
    @(negedge clk); check("latency_1cyc", 32'(lut_valid), 32'h0);
    @(negedge clk); check("latency_2cyc", 32'(lut_valid), 32'h1);
    for (int p = 0; p < 4; p++) begin
      drive(0, 0, 32'h0020_0000, 11'h000, 8'h00);
      drive(3, 1, 32'h0001_0000, 11'h000, 8'h00);
      idle(2, 8'h00);
    end

    // 2: wrap at the top of the address range with +3 modulation
    drive(0, 1, 32'hFFE0_0000, 11'h000, 8'h00);
    idle(1, 8'h00);
    drive(0, 1, 32'h0020_0000, 11'h003, 8'h00);
    idle(1, 8'h00);
    drive(0, 1, 32'h0020_0000, 11'h000, 8'h00);

    // 3: base 5 with -8 modulation
    drive(0, 2, 32'h00A0_0000, 11'h000, 8'h00);
    idle(1, 8'h00);
    drive(0, 2, 32'h0000_0000, 11'h7F8, 8'h00);
    idle(2, 8'h00);

    // 4: note_on hard sync of voice 2, then a pulse coinciding with (2,3)
    drive_voice(2, 32'h1234_5678, 11'h000);
    drive_voice(2, 32'h0040_0000, 11'h000);
    idle(1, 8'h04);
    drive_voice(2, 32'h0060_0000, 11'h000);
    drive_voice(2, 32'h0060_0000, 11'h000);
    for (int o = 0; o < V_OSC - 1; o++) drive(2, o, 32'h0020_0000, 11'h000, 8'h00);
    drive(2, 3, 32'h0020_0000, 11'h000, 8'h04);
    drive_voice(2, 32'h0020_0000, 11'h000);
    idle(2, 8'h00);

    // 5: back-to-back same slot exercises forwarding
    drive(1, 1, 32'h0020_0000, 11'h000, 8'h00);
    drive(1, 1, 32'h0020_0000, 11'h000, 8'h00);
    drive(1, 1, 32'h0020_0000, 11'h005, 8'h00);
    idle(3, 8'h00);

    // Randomised traffic with frequent repeats and occasional note_on
    for (int i = 0; i < 400; i++) begin
      int v, o;
      logic [7:0] non;
      v   = $urandom_range(0, VOICES - 1);
      o   = $urandom_range(0, V_OSC - 1);
      if ($urandom_range(0, 3) == 0) begin v = vx; o = ox; end
      non = ($urandom_range(0, 9) == 0) ? 8'(1 << $urandom_range(0, VOICES - 1)) : 8'h00;
      if ($urandom_range(0, 4) == 0) idle(1, non);
      else drive(v, o, $urandom, 11'($urandom_range(0, 2047)), non);
    end

    // 6: one-cycle reset mid-frame with slots in flight
    drive(4, 0, 32'h0AB0_0000, 11'h000, 8'h00);
    drive(4, 1, 32'h0CD0_0000, 11'h000, 8'h40);
    @(posedge clk); #1;
    slot_valid = 1'b0;
    note_on    = '0;
    rst_n      = 1'b0;
    #1;
    check("midrst_addr",  32'(lut_addr),  32'h0);
    check("midrst_valid", 32'(lut_valid), 32'h0);
    model_clear();
    @(posedge clk); #1; rst_n = 1'b1;
    for (int p = 0; p < 3; p++) begin
      drive(0, 0, 32'h0020_0000, 11'h000, 8'h00);
      drive(4, 1, 32'h0040_0000, 11'h000, 8'h00);
      drive(6, 0, 32'h0040_0000, 11'h000, 8'h00);
    end
    idle(1, 8'h00);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
